// File: rtl/multicycle_seq_ctrl.sv
// Top-level sequencing FSM for the multi-cycle NPC core: fetch, execute, memory access, write-back.
// Owns the instruction register, the PC and the cycle / retired-instruction counters.
module multicycle_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter int unsigned CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  output logic [31:0]      ifu_req_addr,
  input  logic             ifu_rsp_valid,
  input  logic [31:0]      ifu_rsp_inst,
  output logic [31:0]      inst,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_rd_wen,
  input  logic             dec_is_ebreak,
  input  logic [31:0]      next_pc,
  output logic             lsu_req_valid,
  input  logic             lsu_req_ready,
  output logic             lsu_req_wen,
  input  logic             lsu_rsp_valid,
  output logic [31:0]      pc,
  output logic             rf_wen,
  output logic             retire,
  output logic             halt,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_WAIT_INST = 3'd1;
  localparam logic [2:0] S_EXEC      = 3'd2;
  localparam logic [2:0] S_MEM_REQ   = 3'd3;
  localparam logic [2:0] S_MEM_WAIT  = 3'd4;
  localparam logic [2:0] S_WB        = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  logic [2:0] state;
  logic [2:0] state_nxt;
  // Low for the first cycle after reset so no request leaves in the cycle reset deasserts.
  logic       run;
  logic       pc_bad;

  assign pc_bad = misaligned(next_pc);

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:     if (run && ifu_req_ready) state_nxt = S_WAIT_INST;
      S_WAIT_INST: if (ifu_rsp_valid)        state_nxt = S_EXEC;
      S_EXEC: begin
        if (dec_is_ebreak)                    state_nxt = S_HALT;
        else if (dec_is_load || dec_is_store) state_nxt = S_MEM_REQ;
        else                                  state_nxt = S_WB;
      end
      S_MEM_REQ:   if (lsu_req_ready)        state_nxt = S_MEM_WAIT;
      S_MEM_WAIT:  if (lsu_rsp_valid)        state_nxt = S_WB;
      S_WB:        state_nxt = pc_bad ? S_HALT : S_FETCH;
      S_HALT:      state_nxt = S_HALT;
      default:     state_nxt = S_HALT;
    endcase
  end

  // State, IR, PC and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      run         <= 1'b0;
      pc          <= RESET_PC;
      inst        <= 32'h0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      err         <= 1'b0;
    end else begin
      run       <= 1'b1;
      state     <= state_nxt;
      cycle_cnt <= cycle_cnt + CNT_ONE;
      if (state == S_WAIT_INST && ifu_rsp_valid) begin
        inst <= ifu_rsp_inst;
      end
      if (state == S_WB) begin
        instret_cnt <= instret_cnt + CNT_ONE;
        if (pc_bad) begin
          err <= 1'b1;
        end else begin
          pc <= next_pc;
        end
      end
    end
  end

  // Outputs decoded from registered state only; decoder inputs depend on the IR alone.
  assign ifu_req_valid = run && (state == S_FETCH);
  assign ifu_req_addr  = pc;
  assign lsu_req_valid = (state == S_MEM_REQ);
  assign lsu_req_wen   = (state == S_MEM_REQ) && dec_is_store;
  assign retire        = (state == S_WB);
  assign rf_wen        = (state == S_WB) && dec_rd_wen && !dec_is_store;
  assign halt          = (state == S_HALT);

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Bench for multicycle_seq_ctrl: bus responders, a decoder stand-in, a reference model
// feeding expected retirements into queues, and a monitor that pops and compares them.
module tb_multicycle_seq_ctrl;

  localparam logic [31:0] RST_PC   = 32'h80000000;
  localparam int          CW       = 64;
  localparam logic [6:0]  OP_LOAD  = 7'h03;
  localparam logic [6:0]  OP_STORE = 7'h23;
  localparam logic [6:0]  OP_BR    = 7'h63;
  localparam logic [6:0]  OP_JAL   = 7'h6f;
  localparam logic [31:0] EBREAK   = 32'h00100073;
  localparam logic [31:0] ADDI     = 32'h00100093;
  localparam logic [31:0] LW       = 32'h0000a103;
  localparam logic [31:0] SW       = 32'h00112023;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0]   ifu_req_addr, ifu_rsp_inst, inst, next_pc, pc;
  logic          dec_is_load, dec_is_store, dec_rd_wen, dec_is_ebreak;
  logic          lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid;
  logic          rf_wen, retire, halt, err;
  logic [CW-1:0] cycle_cnt, instret_cnt;

  multicycle_seq_ctrl #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst), .inst(inst),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_rd_wen(dec_rd_wen),
    .dec_is_ebreak(dec_is_ebreak), .next_pc(next_pc),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wen(lsu_req_wen),
    .lsu_rsp_valid(lsu_rsp_valid), .pc(pc), .rf_wen(rf_wen), .retire(retire),
    .halt(halt), .err(err), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf;
    logic [63:0] n;
  } ret_t;

  ret_t        ret_q[$];
  logic        lsu_q[$];
  logic [31:0] prog[$];

  int          n_checks = 0, n_fail = 0, n_ret = 0, n_rf = 0;
  logic [63:0] hs_cycle = 0, ret_cycle = 0, rsp_cycle = 0;
  logic [31:0] m_pc = RST_PC;
  logic [63:0] m_instret = 0;
  logic        m_halted = 0;
  logic        rand_en = 0, store_rdwen = 0, misalign = 0;
  int          ifu_pct = 100, lsu_rdy_dly = 0, lsu_rsp_dly = 0;

  // Decoder and branch unit stand-in, driven from the IR
  always_comb begin
    dec_is_ebreak = (inst == EBREAK);
    dec_is_load   = (inst[6:0] == OP_LOAD);
    dec_is_store  = (inst[6:0] == OP_STORE);
    dec_rd_wen    = dec_is_store ? store_rdwen : !(dec_is_ebreak || inst[6:0] == OP_BR);
    if (misalign)                  next_pc = pc + 32'd2;
    else if (inst[6:0] == OP_JAL)  next_pc = pc + 32'd16;
    else                           next_pc = pc + 32'd4;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case ($urandom_range(5))
      0:       op = 7'h13;
      1:       op = 7'h33;
      2:       op = OP_LOAD;
      3:       op = OP_STORE;
      4:       op = OP_JAL;
      default: op = OP_BR;
    endcase
    return {r[31:7], op};
  endfunction

  // Reference model: what each fetched instruction must do when it retires
  task automatic model_issue(input logic [31:0] w);
    logic [31:0] nxt;
    logic [6:0]  op;
    ret_t        rec;
    check("fetch_addr", 64'(ifu_req_addr), 64'(m_pc));
    check("fetch_after_halt", 64'(m_halted), 64'd0);
    op = w[6:0];
    if (w == EBREAK) begin
      m_halted = 1'b1;
      return;
    end
    rec.pc = m_pc;
    rec.rf = !(op == OP_STORE || op == OP_BR);
    rec.n  = m_instret;
    ret_q.push_back(rec);
    m_instret++;
    if (op == OP_LOAD || op == OP_STORE) lsu_q.push_back(op == OP_STORE);
    nxt = m_pc + (misalign ? 32'd2 : (op == OP_JAL ? 32'd16 : 32'd4));
    if (nxt[1:0] != 2'b00) m_halted = 1'b1;
    else                   m_pc = nxt;
  endtask

  // IFU / LSU responders
  initial begin : responder
    logic        ihs, lhs, ibusy, lact, rbusy;
    int          icnt, lcnt, rcnt;
    logic [31:0] iword;
    ibusy = 0; lact = 0; rbusy = 0; icnt = 0; lcnt = 0; rcnt = 0; iword = 0;
    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_inst = 0;
    lsu_req_ready = 0; lsu_rsp_valid = 0;
    forever begin
      @(negedge clk);
      ihs = !rst && ifu_req_valid && ifu_req_ready;
      lhs = !rst && lsu_req_valid && lsu_req_ready;
      if (ihs) begin
        if (prog.size() > 0) iword = prog.pop_front();
        else                 iword = rand_inst();
        hs_cycle = cycle_cnt;
        model_issue(iword);
      end
      @(posedge clk); #1;
      if (rst) begin
        ibusy = 0; lact = 0; rbusy = 0;
        ifu_req_ready = 0; ifu_rsp_valid = 0; lsu_req_ready = 0; lsu_rsp_valid = 0;
      end else begin
        ifu_rsp_valid = 0;
        if (ihs) begin
          ibusy = 1;
          icnt  = rand_en ? $urandom_range(2) : 0;
        end
        if (ibusy) begin
          if (icnt == 0) begin
            ifu_rsp_valid = 1; ifu_rsp_inst = iword; ibusy = 0;
          end else icnt--;
        end else if (rand_en && $urandom_range(7) == 0) begin
          ifu_rsp_valid = 1; ifu_rsp_inst = $urandom;
        end
        ifu_req_ready = (rand_en || prog.size() > 0) && ($urandom_range(99) < ifu_pct);
        lsu_rsp_valid = 0;
        if (lhs) begin
          lsu_req_ready = 0; lact = 0; rbusy = 1;
          rcnt = rand_en ? $urandom_range(3) : lsu_rsp_dly;
        end
        if (rbusy) begin
          if (rcnt == 0) begin
            lsu_rsp_valid = 1; rbusy = 0;
          end else rcnt--;
        end else if (rand_en && !lsu_req_valid && $urandom_range(7) == 0) begin
          lsu_rsp_valid = 1;
        end
        if (lsu_req_valid && !lsu_req_ready) begin
          if (!lact) begin
            lact = 1;
            lcnt = rand_en ? $urandom_range(3) : lsu_rdy_dly;
          end
          if (lcnt == 0) lsu_req_ready = 1;
          else lcnt--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT retires or requests memory
  initial begin : monitor
    logic        ipend, lpend, lwen;
    logic [31:0] iaddr;
    ret_t        r;
    ipend = 0; lpend = 0; lwen = 0; iaddr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ipend = 0; lpend = 0;
      end else begin
        if (retire) begin
          ret_cycle = cycle_cnt;
          n_ret++;
          if (ret_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL retire_unexpected: retire at pc 0x%0h, none required", pc);
          end else begin
            r = ret_q.pop_front();
            check("retire_pc", 64'(pc), 64'(r.pc));
            check("retire_rf_wen", 64'(rf_wen), 64'(r.rf));
            check("retire_instret", instret_cnt, r.n);
          end
        end else begin
          check("rf_wen_idle", 64'(rf_wen), 64'd0);
        end
        if (rf_wen) n_rf++;
        if (lsu_rsp_valid) rsp_cycle = cycle_cnt;
        if (lsu_req_valid) begin
          if (lsu_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL lsu_unexpected: request wen %0d, none required", lsu_req_wen);
          end else begin
            check("lsu_wen", 64'(lsu_req_wen), 64'(lsu_q[0]));
            if (lsu_req_ready) void'(lsu_q.pop_front());
          end
        end
        if (ipend) begin
          check("ifu_valid_held", 64'(ifu_req_valid), 64'd1);
          check("ifu_addr_held", 64'(ifu_req_addr), 64'(iaddr));
        end
        if (lpend) begin
          check("lsu_valid_held", 64'(lsu_req_valid), 64'd1);
          check("lsu_wen_held", 64'(lsu_req_wen), 64'(lwen));
        end
        ipend = ifu_req_valid && !ifu_req_ready; iaddr = ifu_req_addr;
        lpend = lsu_req_valid && !lsu_req_ready; lwen  = lsu_req_wen;
      end
    end
  end

  task automatic wait_retires(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (n_ret < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    n_checks++;
    if (n_ret < target) begin
      n_fail++;
      $display("FAIL %s_timeout: retired %0d, required %0d", tag, n_ret, target);
    end
  endtask

  task automatic clear_model();
    prog.delete(); ret_q.delete(); lsu_q.delete();
    m_pc = RST_PC; m_instret = 0; m_halted = 0;
    n_ret = 0; n_rf = 0; misalign = 0; rand_en = 0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [63:0] c0, i0;
    logic [31:0] p0;
    int          rf0, k;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", 64'(pc), 64'(RST_PC));
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_cycle", cycle_cnt, 64'd0);
    check("rst_instret", instret_cnt, 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_ifu_valid", 64'(ifu_req_valid), 64'd0);
    check("rst_strobes", 64'({lsu_req_valid, rf_wen, retire}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_ifu_valid", 64'(ifu_req_valid), 64'd0);
    check("release_cycle", cycle_cnt, 64'd0);

    // Fetch stall: nothing to return, so ready stays low
    @(negedge clk); #1;
    c0 = cycle_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("stall_valid", 64'(ifu_req_valid), 64'd1);
      check("stall_addr", 64'(ifu_req_addr), 64'(RST_PC));
      check("stall_instret", instret_cnt, 64'd0);
    end
    check("stall_cycles", cycle_cnt, c0 + 64'd5);

    // ALU instruction, zero-wait
    prog.push_back(ADDI);
    wait_retires(1, 30, "addi");
    check("addi_latency", ret_cycle - hs_cycle, 64'd3);
    @(posedge clk); #1;
    check("addi_pc", 64'(pc), 64'h80000004);
    check("addi_instret", instret_cnt, 64'd1);

    // Load with delayed ready and response
    lsu_rdy_dly = 2; lsu_rsp_dly = 2; rf0 = n_rf;
    prog.push_back(LW);
    wait_retires(2, 40, "load");
    check("load_rf_after_rsp", ret_cycle, rsp_cycle + 64'd1);
    @(negedge clk); #1;
    check("load_rf_once", 64'(n_rf - rf0), 64'd1);

    // Store, zero-wait
    lsu_rdy_dly = 0; lsu_rsp_dly = 0; rf0 = n_rf;
    prog.push_back(SW);
    wait_retires(3, 40, "store");
    check("store_latency", ret_cycle - hs_cycle, 64'd5);
    check("store_no_rf", 64'(n_rf - rf0), 64'd0);

    // Random instruction mix with random bus timing
    ifu_pct = 70; store_rdwen = 1; rand_en = 1;
    wait_retires(153, 8000, "random");
    rand_en = 0; ifu_pct = 100;
    k = 0;
    while ((ret_q.size() > 0 || lsu_q.size() > 0) && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    check("drain_queues", 64'(ret_q.size() + lsu_q.size()), 64'd0);
    store_rdwen = 0;

    // ebreak halts without retiring
    prog.push_back(EBREAK);
    k = 0;
    while (!halt && k < 30) begin
      @(negedge clk); #1;
      k++;
    end
    check("ebreak_halt", 64'(halt), 64'd1);
    check("ebreak_halt_cycle", cycle_cnt, hs_cycle + 64'd3);
    c0 = cycle_cnt; i0 = instret_cnt; p0 = pc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("halt_no_fetch", 64'(ifu_req_valid), 64'd0);
      check("halt_no_strobe", 64'({lsu_req_valid, rf_wen, retire}), 64'd0);
    end
    check("halt_cycle_runs", cycle_cnt, c0 + 64'd20);
    check("halt_instret_frozen", instret_cnt, i0);
    check("halt_pc_frozen", 64'(pc), 64'(p0));
    check("halt_err", 64'(err), 64'd0);

    // Misaligned next_pc on the second instruction
    do_reset();
    prog.push_back(ADDI);
    wait_retires(1, 30, "mis_first");
    @(posedge clk); #1;
    misalign = 1;
    prog.push_back(ADDI);
    wait_retires(2, 30, "mis_second");
    @(posedge clk); #1;
    check("mis_err", 64'(err), 64'd1);
    check("mis_halt", 64'(halt), 64'd1);
    check("mis_pc", 64'(pc), 64'h80000004);
    check("mis_instret", instret_cnt, 64'd2);

    // Asynchronous reset in the middle of a fetch
    do_reset();
    prog.push_back(ADDI);
    wait_retires(1, 30, "pre_abort");
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("abort_in_fetch", 64'(ifu_req_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_pc", 64'(pc), 64'(RST_PC));
    check("abort_cycle", cycle_cnt, 64'd0);
    check("abort_instret", instret_cnt, 64'd0);
    check("abort_flags", 64'({halt, err, ifu_req_valid}), 64'd0);
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
